// File: rtl/keyboard_scancode_decoder.sv
// PS/2 Set-2 frame checker and E0/F0 sequence collapser feeding a key-event FIFO.
// Latency 1 from the frame strobe to oKey_Valid. No backpressure: a push into a full FIFO drops the event and sets oOverflow.
// Define KBD_PARITY_CHECK_EN to enable the odd-parity check; otherwise the parity bit is ignored.
module keyboard_scancode_decoder #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iFrame_Valid,
   input  logic [10:0] iFrame,
   input  logic        iKey_Read,
   input  logic        iClear_Errors,
   output logic        oKey_Valid,
   output logic [7:0]  oKey_Code,
   output logic        oKey_Extended,
   output logic        oKey_Release,
   output logic        oFrame_Error,
   output logic        oParity_Error,
   output logic        oOverflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
`ifdef KBD_PARITY_CHECK_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

   state_t      state, state_nxt;
   logic [7:0]  data;
   logic        frame_bad, parity_bad, byte_ok;
   logic        push;
   logic [9:0]  push_dat;
   logic [9:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic        full, pop, wr_en;

   assign data       = iFrame[8:1];
   assign frame_bad  = iFrame[0] | ~iFrame[10];
   assign parity_bad = PAR_EN & ~(^iFrame[9:1]);
   assign byte_ok    = iFrame_Valid & ~frame_bad & ~parity_bad;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_dat  = {2'b00, data};
      if (iFrame_Valid && !byte_ok) begin
         state_nxt = ST_IDLE;
      end else if (byte_ok) begin
         case (state)
            ST_IDLE: begin
               if (data == 8'hE0)      state_nxt = ST_EXT;
               else if (data == 8'hF0) state_nxt = ST_BRK;
               else                    push = 1'b1;
            end
            ST_EXT: begin
               if (data == 8'hF0)      state_nxt = ST_EXT_BRK;
               else if (data != 8'hE0) begin
                  push      = 1'b1;
                  push_dat  = {2'b10, data};
                  state_nxt = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (data == 8'hE0)      state_nxt = ST_EXT_BRK;
               else if (data != 8'hF0) begin
                  push      = 1'b1;
                  push_dat  = {2'b01, data};
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               if (data != 8'hE0 && data != 8'hF0) begin
                  push      = 1'b1;
                  push_dat  = {2'b11, data};
                  state_nxt = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign full  = (count == CNT_FULL);
   assign pop   = iKey_Read & (count != '0);
   assign wr_en = push & (~full | pop);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_en && !pop)      count <= count + CNT_ONE;
         else if (pop && !wr_en) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         oFrame_Error  <= 1'b0;
         oParity_Error <= 1'b0;
         oOverflow     <= 1'b0;
      end else begin
         oFrame_Error  <= (iFrame_Valid & frame_bad)  | (oFrame_Error  & ~iClear_Errors);
         oParity_Error <= (iFrame_Valid & parity_bad) | (oParity_Error & ~iClear_Errors);
         oOverflow     <= (push & full & ~pop)        | (oOverflow     & ~iClear_Errors);
      end
   end

   assign oKey_Valid    = (count != '0);
   assign oKey_Extended = mem[rd_ptr][9];
   assign oKey_Release  = mem[rd_ptr][8];
   assign oKey_Code     = mem[rd_ptr][7:0];

endmodule

// File: tb/tb_keyboard_scancode_decoder.sv
// Randomised and directed bench for keyboard_scancode_decoder against a queue-based event model.
module tb_keyboard_scancode_decoder;

   localparam int DEPTH = 8;
`ifdef KBD_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iFrame_Valid, iKey_Read, iClear_Errors;
   logic [10:0] iFrame;
   logic        oKey_Valid, oKey_Extended, oKey_Release;
   logic [7:0]  oKey_Code;
   logic        oFrame_Error, oParity_Error, oOverflow;

   keyboard_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .Clock(Clock), .Reset(Reset), .iFrame_Valid(iFrame_Valid), .iFrame(iFrame),
      .iKey_Read(iKey_Read), .iClear_Errors(iClear_Errors), .oKey_Valid(oKey_Valid),
      .oKey_Code(oKey_Code), .oKey_Extended(oKey_Extended), .oKey_Release(oKey_Release),
      .oFrame_Error(oFrame_Error), .oParity_Error(oParity_Error), .oOverflow(oOverflow)
   );

   always #5 Clock = ~Clock;

   int n_chk = 0;
   int n_err = 0;

   // Model: pending-prefix booleans plus a queue of {ext, rel, code} events.
   logic [9:0] q[$];
   bit m_ext, m_rel, m_ferr, m_perr, m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par = 0,
                                      input bit bad_start = 0, input bit bad_stop = 0);
      logic p;
      p = (~^b) ^ bad_par;
      return {~bad_stop, p, b, bad_start};
   endfunction

   task automatic model_reset();
      q.delete();
      m_ext = 0; m_rel = 0; m_ferr = 0; m_perr = 0; m_ovf = 0;
   endtask

   task automatic model(input bit v, input logic [10:0] f, input bit rd, input bit clr);
      bit popping, fe, pe, was_full;
      logic [7:0] b;
      popping  = rd && (q.size() > 0);
      was_full = (q.size() == DEPTH);
      fe = v && (f[0] || !f[10]);
      pe = v && PAR_EN && !(^f[9:1]);
      b  = f[8:1];
      if (clr) begin m_ferr = 0; m_perr = 0; m_ovf = 0; end
      if (fe) m_ferr = 1;
      if (pe) m_perr = 1;
      if (popping) void'(q.pop_front());
      if (v) begin
         if (fe || pe) begin
            m_ext = 0; m_rel = 0;
         end else if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0)     m_rel = 1;
         else begin
            if (was_full && !popping) m_ovf = 1;
            else q.push_back({m_ext, m_rel, b});
            m_ext = 0; m_rel = 0;
         end
      end
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_vld"}, 32'(oKey_Valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk({tag, "_code"}, 32'(oKey_Code), 32'(q[0][7:0]));
         chk({tag, "_ext"},  32'(oKey_Extended), 32'(q[0][9]));
         chk({tag, "_rel"},  32'(oKey_Release), 32'(q[0][8]));
      end
      chk({tag, "_ferr"}, 32'(oFrame_Error), 32'(m_ferr));
      chk({tag, "_perr"}, 32'(oParity_Error), 32'(m_perr));
      chk({tag, "_ovf"},  32'(oOverflow), 32'(m_ovf));
   endtask

   // Called at a falling edge; drives one cycle of inputs and checks after the next rising edge.
   task automatic step(input string tag, input bit v, input logic [10:0] f, input bit rd, input bit clr);
      iFrame_Valid  = v;
      iFrame        = f;
      iKey_Read     = rd;
      iClear_Errors = clr;
      model(v, f, rd, clr);
      @(posedge Clock);
      @(negedge Clock);
      iFrame_Valid  = 0;
      iKey_Read     = 0;
      iClear_Errors = 0;
      check_out(tag);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < DEPTH + 1; i++) step(tag, 0, 11'h0, 1, 0);
   endtask

   initial begin
      Reset = 0; iFrame_Valid = 0; iFrame = '0; iKey_Read = 0; iClear_Errors = 0;
      model_reset();
      #12;
      chk("rst_vld",  32'(oKey_Valid), 0);
      chk("rst_code", 32'(oKey_Code), 0);
      chk("rst_ext",  32'(oKey_Extended), 0);
      chk("rst_rel",  32'(oKey_Release), 0);
      chk("rst_flags", {29'd0, oFrame_Error, oParity_Error, oOverflow}, 0);
      @(negedge Clock);
      Reset = 1;
      @(negedge Clock);

      // Plain make code, then pop.
      step("mk1c", 1, mk(8'h1C), 0, 0);
      chk("mk1c_code_abs", 32'(oKey_Code), 32'h1C);
      step("pop1c", 0, 11'h0, 1, 0);
      chk("pop1c_empty", 32'(oKey_Valid), 0);

      // Extended break sequence collapses to one event.
      step("e0", 1, mk(8'hE0), 0, 0);
      step("f0", 1, mk(8'hF0), 0, 0);
      step("x75", 1, mk(8'h75), 0, 0);
      chk("x75_abs", {22'd0, oKey_Extended, oKey_Release, oKey_Code}, {22'd0, 2'b11, 8'h75});
      drain("drain_a");

      // Wrong parity: dropped only when the check is compiled in.
      step("badpar", 1, mk(8'h1C, 1), 0, 0);
      drain("drain_b");
      step("clr_b", 0, 11'h0, 0, 1);

      // Framing error after E0 loses the prefix.
      step("e0b", 1, mk(8'hE0), 0, 0);
      step("badstop", 1, mk(8'h12, 0, 0, 1), 0, 0);
      chk("badstop_abs", 32'(oFrame_Error), 1);
      step("after_err", 1, mk(8'h1C), 0, 0);
      step("clr_c", 0, 11'h0, 0, 1);
      chk("clr_c_abs", 32'(oFrame_Error), 0);
      drain("drain_c");

      // Fill past depth, clear, then push+pop while full.
      for (int i = 1; i <= 9; i++) step("fill", 1, mk(8'(i)), 0, 0);
      chk("fill_ovf_abs", 32'(oOverflow), 1);
      step("clr_d", 0, 11'h0, 0, 1);
      step("full_pp", 1, mk(8'h0A), 1, 0);
      chk("full_pp_ovf_abs", 32'(oOverflow), 0);
      drain("drain_d");

      // Reset in the middle of a prefix sequence.
      step("e0r", 1, mk(8'hE0), 0, 0);
      step("pre_rst", 1, mk(8'h33), 0, 0);
      Reset = 0;
      model_reset();
      #2;
      chk("midrst_vld", 32'(oKey_Valid), 0);
      @(negedge Clock);
      Reset = 1;
      @(negedge Clock);
      step("post_rst", 1, mk(8'h1C), 0, 0);
      drain("drain_e");

      // Random traffic with prefix-heavy bytes and occasional bad frames.
      for (int i = 0; i < 600; i++) begin
         int r, e;
         logic [7:0] b;
         bit v, rd, clr;
         r = $urandom_range(0, 9);
         b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
         e = $urandom_range(0, 15);
         v = ($urandom_range(0, 3) != 0);
         rd = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
         clr = ($urandom_range(0, 19) == 0);
         step("rnd", v, mk(b, e == 0, e == 1, e == 2), rd, clr);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
